// File: rtl/post_current_accumulator_if.sv
// Bus bundle for post_current_accumulator.
// Carries the update stream in, the clear/drain command pulses, the drain
// stream out and the status outputs. The slave modport is the accumulator
// side; the master modport is the side that drives updates and commands.
interface post_current_accumulator_if;
  logic        i_curr_valid;
  logic [31:0] i_curr_value;
  logic [15:0] i_curr_idx;
  logic        o_curr_ready;
  logic        i_clear;
  logic        i_drain;
  logic        o_busy;
  logic        o_done;
  logic        o_acc_valid;
  logic [15:0] o_acc_idx;
  logic [31:0] o_acc_value;
  logic        i_acc_ready;
  logic        o_sat;
  logic [15:0] o_drop_cnt;

  modport slave (
    input  i_curr_valid, i_curr_value, i_curr_idx, i_clear, i_drain, i_acc_ready,
    output o_curr_ready, o_busy, o_done, o_acc_valid, o_acc_idx, o_acc_value,
           o_sat, o_drop_cnt
  );

  modport master (
    output i_curr_valid, i_curr_value, i_curr_idx, i_clear, i_drain, i_acc_ready,
    input  o_curr_ready, o_busy, o_done, o_acc_valid, o_acc_idx, o_acc_value,
           o_sat, o_drop_cnt
  );
endinterface

// File: rtl/post_current_accumulator.sv
// Postsynaptic current accumulator.
// Accepts (idx, dI) updates at one per cycle and read-modify-write accumulates
// them with signed saturation into a per-neuron current memory. A clear
// command zeroes every entry; a drain command streams every entry out in
// index order and zeroes it behind the handshake.
// Ports: clk, rst (async, active-high), bus (slave modport): update stream
// i_curr_*/o_curr_ready, commands i_clear/i_drain, status o_busy/o_done,
// drain stream o_acc_*/i_acc_ready, sticky o_sat, saturating o_drop_cnt.
module post_current_accumulator #(
  parameter int unsigned N_POST = 4096,
  parameter int unsigned ADDRW  = 12
) (
  input logic                       clk,
  input logic                       rst,
  post_current_accumulator_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned IW = 16;
  localparam logic [ADDRW-1:0] ADDR_LAST = ADDRW'(N_POST - 1);

  typedef enum logic [2:0] {
    S_ACCUM, S_CLEAR, S_FLUSH, S_DRAIN_RD, S_DRAIN_OUT
  } state_t;

  state_t state, state_nxt;

  // Accumulator storage: one write port, one registered read port (read-first).
  logic [DW-1:0]    mem [N_POST];
  logic [DW-1:0]    rdata;
  logic             re;
  logic [ADDRW-1:0] raddr;
  logic             we;
  logic [ADDRW-1:0] waddr;
  logic [DW-1:0]    wdata;

  // Stage B registers and sweep address.
  logic             b_valid, b_valid_nxt;
  logic             b_hazard, b_hazard_nxt;
  logic [ADDRW-1:0] b_idx, b_idx_nxt;
  logic [DW-1:0]    b_value, b_value_nxt;
  logic [DW-1:0]    last_sum, last_sum_nxt;
  logic [ADDRW-1:0] addr, addr_nxt;

  // Registered outputs.
  logic          ready_q, ready_nxt;
  logic          busy_q, busy_nxt;
  logic          done_q, done_nxt;
  logic          acc_valid_q, acc_valid_nxt;
  logic [IW-1:0] acc_idx_q, acc_idx_nxt;
  logic          sat_q, sat_nxt;
  logic [IW-1:0] drop_q, drop_nxt;

  // Shared decode.
  logic             accept, in_range, hs, clr_step, at_last;
  logic [ADDRW-1:0] new_idx;
  logic [DW-1:0]    base, sum_sat;
  logic [DW:0]      sum_ext;
  logic             ovf;

  assign accept   = bus.i_curr_valid && ready_q;
  assign in_range = 32'(bus.i_curr_idx) < N_POST;
  assign new_idx  = bus.i_curr_idx[ADDRW-1:0];
  assign hs       = (state == S_DRAIN_OUT) && acc_valid_q && bus.i_acc_ready;
  // Clear sweep stalls while a stage-B write from the entry cycle commits.
  assign clr_step = (state == S_CLEAR) && !b_valid;
  assign at_last  = (addr == ADDR_LAST);

  // Stage B: pick forwarded sum on back-to-back same-index, add at 33 bits, saturate.
  assign base    = b_hazard ? last_sum : rdata;
  assign sum_ext = {b_value[DW-1], b_value} + {base[DW-1], base};
  assign ovf     = sum_ext[DW] ^ sum_ext[DW-1];
  assign sum_sat = ovf ? (sum_ext[DW] ? 32'h8000_0000 : 32'h7FFF_FFFF) : sum_ext[DW-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACCUM;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_ACCUM: begin
        if (bus.i_clear)      state_nxt = S_CLEAR;
        else if (bus.i_drain) state_nxt = S_FLUSH;
      end
      S_CLEAR:     if (clr_step && at_last) state_nxt = S_ACCUM;
      S_FLUSH:     if (!b_valid) state_nxt = S_DRAIN_RD;
      S_DRAIN_RD:  state_nxt = S_DRAIN_OUT;
      S_DRAIN_OUT: if (hs) state_nxt = at_last ? S_ACCUM : S_DRAIN_RD;
      default:     state_nxt = S_ACCUM;
    endcase
  end

  // Output / datapath decode: memory port control and next register values.
  always_comb begin
    re            = 1'b0;
    raddr         = new_idx;
    we            = 1'b0;
    waddr         = b_idx;
    wdata         = sum_sat;
    b_valid_nxt   = accept && in_range;
    b_hazard_nxt  = b_valid && (b_idx == new_idx);
    b_idx_nxt     = new_idx;
    b_value_nxt   = bus.i_curr_value;
    last_sum_nxt  = b_valid ? sum_sat : last_sum;
    addr_nxt      = addr;
    done_nxt      = (clr_step || hs) && at_last;
    acc_valid_nxt = (state == S_DRAIN_RD) ||
                    ((state == S_DRAIN_OUT) && acc_valid_q && !bus.i_acc_ready);
    acc_idx_nxt   = (state == S_DRAIN_RD) ? IW'(addr) : acc_idx_q;
    sat_nxt       = sat_q || (b_valid && ovf);
    drop_nxt      = drop_q;

    if (accept && in_range) re = 1'b1;
    if (accept && !in_range && (drop_q != 16'hFFFF)) drop_nxt = drop_q + 16'd1;

    // Write port: in-flight update first, then clear sweep, then drain zeroing.
    if (b_valid) begin
      we = 1'b1;
    end else if (clr_step || hs) begin
      we    = 1'b1;
      waddr = addr;
      wdata = '0;
    end

    unique case (state)
      S_ACCUM:     addr_nxt = '0;
      S_CLEAR: begin
        sat_nxt  = 1'b0;
        drop_nxt = '0;
        if (clr_step) addr_nxt = addr + ADDRW'(1);
      end
      S_FLUSH:     addr_nxt = '0;
      S_DRAIN_RD: begin
        re    = 1'b1;
        raddr = addr;
      end
      S_DRAIN_OUT: if (hs) addr_nxt = addr + ADDRW'(1);
      default:     addr_nxt = '0;
    endcase

    ready_nxt = (state_nxt == S_ACCUM);
    busy_nxt  = (state_nxt != S_ACCUM) || b_valid_nxt;
  end

  // Pipeline and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_valid     <= 1'b0;
      b_hazard    <= 1'b0;
      b_idx       <= '0;
      b_value     <= '0;
      last_sum    <= '0;
      addr        <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      acc_valid_q <= 1'b0;
      acc_idx_q   <= '0;
      sat_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      b_valid     <= b_valid_nxt;
      b_hazard    <= b_hazard_nxt;
      b_idx       <= b_idx_nxt;
      b_value     <= b_value_nxt;
      last_sum    <= last_sum_nxt;
      addr        <= addr_nxt;
      ready_q     <= ready_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      acc_valid_q <= acc_valid_nxt;
      acc_idx_q   <= acc_idx_nxt;
      sat_q       <= sat_nxt;
      drop_q      <= drop_nxt;
    end
  end

  // Memory array (no reset).
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read data register; holds while no read is issued, so it doubles as the drain value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

  assign bus.o_curr_ready = ready_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_acc_valid  = acc_valid_q;
  assign bus.o_acc_idx    = acc_idx_q;
  assign bus.o_acc_value  = rdata;
  assign bus.o_sat        = sat_q;
  assign bus.o_drop_cnt   = drop_q;
endmodule

// File: tb/tb_post_current_accumulator.sv
// Directed testbench for post_current_accumulator: reset values, clear sweep,
// accumulate with forwarding, saturation, out-of-range drops, drain with and
// without back-pressure, and reset during a drain.
module tb_post_current_accumulator;
  localparam int unsigned N_POST = 4096;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  logic [31:0] dvals [N_POST];

  post_current_accumulator_if bus_if ();

  post_current_accumulator #(.N_POST(N_POST), .ADDRW(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one update for one clock; caller deasserts valid when done.
  task automatic send(input logic [15:0] idx, input logic [31:0] val);
    bus_if.i_curr_valid = 1'b1;
    bus_if.i_curr_idx   = idx;
    bus_if.i_curr_value = val;
    @(posedge clk); #1;
  endtask

  // Issue a drain and collect every handshaken output into dvals.
  task automatic run_drain(input bit stall, input bit with_upd, input logic [15:0] uidx,
                           input logic [31:0] uval, output int n_out, output int order_err,
                           output int stable_err, output int stalls, output bit done_seen);
    int cyc;
    int exp_idx;
    bit holding;
    logic [15:0] h_idx;
    logic [31:0] h_val;
    n_out = 0; order_err = 0; stable_err = 0; stalls = 0; done_seen = 1'b0;
    cyc = 0; exp_idx = 0; holding = 1'b0; h_idx = '0; h_val = '0;
    for (int i = 0; i < int'(N_POST); i++) dvals[i] = 32'hDEAD_BEEF;
    bus_if.i_drain = 1'b1;
    if (with_upd) begin
      bus_if.i_curr_valid = 1'b1;
      bus_if.i_curr_idx   = uidx;
      bus_if.i_curr_value = uval;
    end
    @(posedge clk); #1;
    bus_if.i_drain      = 1'b0;
    bus_if.i_curr_valid = 1'b0;
    while (!done_seen && cyc < 40000) begin
      bus_if.i_acc_ready = stall ? (cyc % 3 == 2) : 1'b1;
      if (bus_if.o_acc_valid) begin
        if (holding && (bus_if.o_acc_idx !== h_idx || bus_if.o_acc_value !== h_val))
          stable_err++;
        if (bus_if.i_acc_ready) begin
          if (bus_if.o_acc_idx !== 16'(exp_idx)) order_err++;
          if (bus_if.o_acc_idx < 16'(N_POST)) dvals[bus_if.o_acc_idx[11:0]] = bus_if.o_acc_value;
          n_out++;
          exp_idx++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          stalls++;
          h_idx = bus_if.o_acc_idx;
          h_val = bus_if.o_acc_value;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (bus_if.o_done) done_seen = 1'b1;
    end
    bus_if.i_acc_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus_if.o_curr_ready !== 1'b0) $display("FAIL reset_ready: got %0b expected 0", bus_if.o_curr_ready); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus_if.o_busy); else n_pass++;
    n_checks++; if (bus_if.o_done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus_if.o_done); else n_pass++;
    n_checks++; if (bus_if.o_acc_valid !== 1'b0) $display("FAIL reset_acc_valid: got %0b expected 0", bus_if.o_acc_valid); else n_pass++;
    n_checks++; if (bus_if.o_acc_idx !== 16'd0) $display("FAIL reset_acc_idx: got %0h expected 0", bus_if.o_acc_idx); else n_pass++;
    n_checks++; if (bus_if.o_acc_value !== 32'd0) $display("FAIL reset_acc_value: got %0h expected 0", bus_if.o_acc_value); else n_pass++;
    n_checks++; if (bus_if.o_sat !== 1'b0) $display("FAIL reset_sat: got %0b expected 0", bus_if.o_sat); else n_pass++;
    n_checks++; if (bus_if.o_drop_cnt !== 16'd0) $display("FAIL reset_drop: got %0h expected 0", bus_if.o_drop_cnt); else n_pass++;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus_if.o_curr_ready !== 1'b1) $display("FAIL post_reset_ready: got %0b expected 1", bus_if.o_curr_ready); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL post_reset_busy: got %0b expected 0", bus_if.o_busy); else n_pass++;
  endtask

  // Clear sweep: exactly N_POST cycles after the entry edge, then flags zeroed.
  task automatic test_clear(input string tag);
    int cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    bus_if.i_clear = 1'b1;
    @(posedge clk); #1;
    bus_if.i_clear = 1'b0;
    while (!seen && cyc < 10000) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 10) begin
        n_checks++; if (bus_if.o_busy !== 1'b1) $display("FAIL %s_busy_mid: got %0b expected 1", tag, bus_if.o_busy); else n_pass++;
        n_checks++; if (bus_if.o_curr_ready !== 1'b0) $display("FAIL %s_ready_mid: got %0b expected 0", tag, bus_if.o_curr_ready); else n_pass++;
      end
      if (bus_if.o_done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b1) $display("FAIL %s_done_seen: got %0b expected 1", tag, seen); else n_pass++;
    n_checks++; if (cyc != int'(N_POST)) $display("FAIL %s_cycles: got %0d expected %0d", tag, cyc, N_POST); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL %s_busy_end: got %0b expected 0", tag, bus_if.o_busy); else n_pass++;
    n_checks++; if (bus_if.o_sat !== 1'b0) $display("FAIL %s_sat: got %0b expected 0", tag, bus_if.o_sat); else n_pass++;
    n_checks++; if (bus_if.o_drop_cnt !== 16'd0) $display("FAIL %s_drop: got %0h expected 0", tag, bus_if.o_drop_cnt); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_done !== 1'b0) $display("FAIL %s_done_pulse: got %0b expected 0", tag, bus_if.o_done); else n_pass++;
    n_checks++; if (bus_if.o_curr_ready !== 1'b1) $display("FAIL %s_ready_end: got %0b expected 1", tag, bus_if.o_curr_ready); else n_pass++;
  endtask

  task automatic test_drain_zero;
    int n_out, order_err, stable_err, stalls, nz;
    bit done_seen;
    run_drain(1'b0, 1'b0, 16'd0, 32'd0, n_out, order_err, stable_err, stalls, done_seen);
    nz = 0;
    for (int i = 0; i < int'(N_POST); i++) if (dvals[i] !== 32'd0) nz++;
    n_checks++; if (done_seen !== 1'b1) $display("FAIL dz_done: got %0b expected 1", done_seen); else n_pass++;
    n_checks++; if (n_out != int'(N_POST)) $display("FAIL dz_count: got %0d expected %0d", n_out, N_POST); else n_pass++;
    n_checks++; if (order_err != 0) $display("FAIL dz_order: got %0d errors expected 0", order_err); else n_pass++;
    n_checks++; if (nz != 0) $display("FAIL dz_values: got %0d nonzero expected 0", nz); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL dz_busy: got %0b expected 0", bus_if.o_busy); else n_pass++;
  endtask

  task automatic test_accumulate;
    int n_out, order_err, stable_err, stalls, nz;
    bit done_seen;
    n_checks++; if (bus_if.o_curr_ready !== 1'b1) $display("FAIL acc_ready: got %0b expected 1", bus_if.o_curr_ready); else n_pass++;
    // Back-to-back same index, a different index between, then distance-2 reuse.
    send(16'd5, 32'd100);
    send(16'd5, 32'd200);
    send(16'd5, -32'sd50);
    send(16'd6, 32'd7);
    send(16'd5, 32'd1000);
    bus_if.i_curr_valid = 1'b0;
    n_checks++; if (bus_if.o_busy !== 1'b1) $display("FAIL acc_busy_pipe: got %0b expected 1", bus_if.o_busy); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL acc_busy_idle: got %0b expected 0", bus_if.o_busy); else n_pass++;
    n_checks++; if (bus_if.o_sat !== 1'b0) $display("FAIL acc_sat_clean: got %0b expected 0", bus_if.o_sat); else n_pass++;
    // Positive and negative saturation.
    send(16'd9, 32'h7FFF_FF00);
    send(16'd9, 32'h0000_0200);
    send(16'd10, 32'h8000_0000);
    send(16'd10, 32'hFFFF_FFFF);
    bus_if.i_curr_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_sat !== 1'b1) $display("FAIL acc_sat_set: got %0b expected 1", bus_if.o_sat); else n_pass++;
    // Out-of-range drops alias onto idx 0 / 4095 if not dropped.
    send(16'd4095, 32'd3);
    send(16'd4096, 32'd55);
    send(16'd0, 32'd4);
    send(16'hFFFF, 32'd66);
    bus_if.i_curr_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_drop_cnt !== 16'd2) $display("FAIL acc_drop_cnt: got %0d expected 2", bus_if.o_drop_cnt); else n_pass++;
    // Update accepted in the drain command cycle must land before the drain.
    run_drain(1'b0, 1'b1, 16'd4095, 32'd2, n_out, order_err, stable_err, stalls, done_seen);
    nz = 0;
    for (int i = 0; i < int'(N_POST); i++)
      if (!(i == 0 || i == 5 || i == 6 || i == 9 || i == 10 || i == 4095) && dvals[i] !== 32'd0) nz++;
    n_checks++; if (done_seen !== 1'b1) $display("FAIL acc_drain_done: got %0b expected 1", done_seen); else n_pass++;
    n_checks++; if (n_out != int'(N_POST)) $display("FAIL acc_drain_count: got %0d expected %0d", n_out, N_POST); else n_pass++;
    n_checks++; if (order_err != 0) $display("FAIL acc_drain_order: got %0d errors expected 0", order_err); else n_pass++;
    n_checks++; if (dvals[5] !== 32'd1250) $display("FAIL acc_idx5: got %0d expected 1250", dvals[5]); else n_pass++;
    n_checks++; if (dvals[6] !== 32'd7) $display("FAIL acc_idx6: got %0d expected 7", dvals[6]); else n_pass++;
    n_checks++; if (dvals[9] !== 32'h7FFF_FFFF) $display("FAIL acc_sat_pos: got %0h expected 7fffffff", dvals[9]); else n_pass++;
    n_checks++; if (dvals[10] !== 32'h8000_0000) $display("FAIL acc_sat_neg: got %0h expected 80000000", dvals[10]); else n_pass++;
    n_checks++; if (dvals[0] !== 32'd4) $display("FAIL acc_idx0: got %0d expected 4", dvals[0]); else n_pass++;
    n_checks++; if (dvals[4095] !== 32'd5) $display("FAIL acc_idx4095: got %0d expected 5", dvals[4095]); else n_pass++;
    n_checks++; if (nz != 0) $display("FAIL acc_others: got %0d nonzero expected 0", nz); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL acc_drain_busy: got %0b expected 0", bus_if.o_busy); else n_pass++;
  endtask

  task automatic test_stall_drain;
    int n_out, order_err, stable_err, stalls, nz;
    bit done_seen;
    run_drain(1'b1, 1'b0, 16'd0, 32'd0, n_out, order_err, stable_err, stalls, done_seen);
    nz = 0;
    for (int i = 0; i < int'(N_POST); i++) if (dvals[i] !== 32'd0) nz++;
    n_checks++; if (done_seen !== 1'b1) $display("FAIL st_done: got %0b expected 1", done_seen); else n_pass++;
    n_checks++; if (n_out != int'(N_POST)) $display("FAIL st_count: got %0d expected %0d", n_out, N_POST); else n_pass++;
    n_checks++; if (order_err != 0) $display("FAIL st_order: got %0d errors expected 0", order_err); else n_pass++;
    n_checks++; if (stalls == 0) $display("FAIL st_stalls: got %0d stalls expected >0", stalls); else n_pass++;
    n_checks++; if (stable_err != 0) $display("FAIL st_stable: got %0d changes expected 0", stable_err); else n_pass++;
    n_checks++; if (nz != 0) $display("FAIL st_read_clear: got %0d nonzero expected 0", nz); else n_pass++;
    n_checks++; if (bus_if.o_sat !== 1'b1) $display("FAIL st_sat_kept: got %0b expected 1", bus_if.o_sat); else n_pass++;
    n_checks++; if (bus_if.o_drop_cnt !== 16'd2) $display("FAIL st_drop_kept: got %0d expected 2", bus_if.o_drop_cnt); else n_pass++;
  endtask

  task automatic test_reset_mid_drain;
    bit found;
    found = 1'b0;
    bus_if.i_acc_ready = 1'b1;
    bus_if.i_drain = 1'b1;
    @(posedge clk); #1;
    bus_if.i_drain = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      if (bus_if.o_acc_valid && bus_if.o_acc_idx == 16'd100) begin
        found = 1'b1;
        bus_if.i_acc_ready = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rd_reach_100: got %0b expected 1", found); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_acc_valid !== 1'b1) $display("FAIL rd_stalled_valid: got %0b expected 1", bus_if.o_acc_valid); else n_pass++;
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    n_checks++; if (bus_if.o_acc_valid !== 1'b0) $display("FAIL rd_acc_valid: got %0b expected 0", bus_if.o_acc_valid); else n_pass++;
    n_checks++; if (bus_if.o_busy !== 1'b0) $display("FAIL rd_busy: got %0b expected 0", bus_if.o_busy); else n_pass++;
    n_checks++; if (bus_if.o_done !== 1'b0) $display("FAIL rd_done_rst: got %0b expected 0", bus_if.o_done); else n_pass++;
    rst = 1'b0;
    bus_if.i_acc_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus_if.o_curr_ready !== 1'b1) $display("FAIL rd_ready: got %0b expected 1", bus_if.o_curr_ready); else n_pass++;
    n_checks++; if (bus_if.o_done !== 1'b0) $display("FAIL rd_done_after: got %0b expected 0", bus_if.o_done); else n_pass++;
    n_checks++; if (bus_if.o_acc_valid !== 1'b0) $display("FAIL rd_valid_after: got %0b expected 0", bus_if.o_acc_valid); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst                 = 1'b1;
    bus_if.i_curr_valid = 1'b0;
    bus_if.i_curr_value = '0;
    bus_if.i_curr_idx   = '0;
    bus_if.i_clear      = 1'b0;
    bus_if.i_drain      = 1'b0;
    bus_if.i_acc_ready  = 1'b1;

    test_reset();
    test_clear("clear_init");
    test_drain_zero();
    test_accumulate();
    test_stall_drain();
    test_clear("clear_flags");
    test_reset_mid_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
